// File: rtl/snn_lif_bank_pkg.sv
// rtl/snn_lif_bank_pkg.sv - shared types, defaults and saturating add for the LIF neuron bank
package snn_pkg;

    // Defaults shared with the convolution/linear stages feeding the bank
    localparam int SNN_VW         = 35;
    localparam int SNN_LEAK_SHIFT = 4;

    // Widest membrane the generic saturating helper supports
    localparam int SAT_MAXW = 64;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FIN
    } lif_state_t;

    // Add two sign-extended operands one bit wider than the carrier, then clamp
    // the sum into the signed range of a w-bit word; the caller narrows to w bits.
    function automatic logic signed [SAT_MAXW-1:0] sat_add(
        input logic signed [SAT_MAXW-1:0] a,
        input logic signed [SAT_MAXW-1:0] b,
        input int unsigned                w
    );
        logic signed [SAT_MAXW:0] sum;
        logic signed [SAT_MAXW:0] lo;
        logic signed [SAT_MAXW:0] hi;
        sum = {a[SAT_MAXW-1], a} + {b[SAT_MAXW-1], b};
        lo  = -((SAT_MAXW+1)'(1) << (w - 1));
        hi  = ~lo;
        if (sum > hi) begin
            return hi[SAT_MAXW-1:0];
        end else if (sum < lo) begin
            return lo[SAT_MAXW-1:0];
        end
        return sum[SAT_MAXW-1:0];
    endfunction

endpackage

// File: rtl/snn_lif_bank_if.sv
// rtl/snn_lif_bank_if.sv - current-in and spike-out stream bundle of the LIF neuron bank
interface snn_lif_bank_if
    import snn_pkg::*;
#(
    parameter int LANES = 16,
    parameter int VW    = SNN_VW
);
    logic                  cur_valid;
    logic                  cur_ready;
    logic [LANES*VW-1:0]   cur_data;
    logic                  spk_valid;
    logic                  spk_ready;
    logic [LANES-1:0]      spk_data;

    modport master (
        output cur_valid, cur_data, spk_ready,
        input  cur_ready, spk_valid, spk_data
    );

    modport slave (
        input  cur_valid, cur_data, spk_ready,
        output cur_ready, spk_valid, spk_data
    );
endinterface

// File: rtl/snn_lif_bank_lane.sv
// rtl/snn_lif_bank_lane.sv - combinational leak/integrate/fire/reset for one neuron
module lif_lane
    import snn_pkg::*;
#(
    parameter int VW         = SNN_VW,
    parameter int LEAK_SHIFT = SNN_LEAK_SHIFT
)(
    input  logic signed [VW-1:0] v_in,
    input  logic signed [VW-1:0] i_in,
    input  logic signed [VW-1:0] thr,
    input  logic                 leak_en,
    input  logic                 sub_reset,
    output logic signed [VW-1:0] v_out,
    output logic                 fire
);
    logic signed [SAT_MAXW-1:0] v_x;
    logic signed [SAT_MAXW-1:0] vl_x;
    logic signed [SAT_MAXW-1:0] thr_x;
    logic signed [VW-1:0]       vi;
    logic signed [VW-1:0]       vs;

    // Leak cannot overflow (v - v/2^k stays inside v's range), so only the
    // integrate and subtract-reset steps need saturation.
    always_comb begin
        v_x   = SAT_MAXW'(v_in);
        thr_x = SAT_MAXW'(thr);
        vl_x  = leak_en ? (v_x - (v_x >>> LEAK_SHIFT)) : v_x;
        vi    = VW'(sat_add(vl_x, SAT_MAXW'(i_in), VW));
        vs    = VW'(sat_add(SAT_MAXW'(vi), -thr_x, VW));
        fire  = (vi >= thr);
        if (fire) begin
            v_out = sub_reset ? vs : '0;
        end else begin
            v_out = vi;
        end
    end
endmodule

// File: rtl/snn_lif_bank.sv
// rtl/snn_lif_bank.sv - time-multiplexed bank of leaky integrate-and-fire neurons
module snn_lif_bank
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS = 4096,
    parameter int LANES       = 16,
    parameter int VW          = SNN_VW,
    parameter int LEAK_SHIFT  = SNN_LEAK_SHIFT,
    localparam int BEATS      = NUM_NEURONS / LANES,
    localparam int PW         = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int CW         = $clog2(NUM_NEURONS + 1)
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic                 clear,
    input  logic signed [VW-1:0] cfg_threshold,
    input  logic                 cfg_leak_en,
    input  logic                 cfg_sub_reset,
    snn_lif_bank_if.slave        bus,
    output logic [CW-1:0]        spk_count,
    output logic                 busy,
    output logic                 done
);
    lif_state_t            state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic                  spk_valid_q, spk_valid_d;
    logic [LANES-1:0]      spk_data_q, spk_data_d;
    logic [CW-1:0]         spk_count_q, spk_count_d;

    logic [LANES*VW-1:0]   mem_q [BEATS];
    logic                  mem_we;
    logic [LANES*VW-1:0]   mem_wdata;
    logic [LANES*VW-1:0]   row_rd;
    logic [LANES*VW-1:0]   lane_v;
    logic [LANES-1:0]      lane_fire;
    logic                  cur_ready_c;
    logic                  last_row;

    function automatic logic [CW-1:0] popcount(input logic [LANES-1:0] bits);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + CW'(bits[i]);
        end
        return n;
    endfunction

    // The row under the pointer is read combinationally and written back on the
    // accepting edge, so consecutive beats always see fresh membranes.
    assign row_rd   = mem_q[ptr_q];
    assign last_row = (ptr_q == PW'(BEATS - 1));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        lif_lane #(
            .VW         (VW),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .v_in      (row_rd[l*VW +: VW]),
            .i_in      (bus.cur_data[l*VW +: VW]),
            .thr       (cfg_threshold),
            .leak_en   (cfg_leak_en),
            .sub_reset (cfg_sub_reset),
            .v_out     (lane_v[l*VW +: VW]),
            .fire      (lane_fire[l])
        );
    end

    // Next-state logic: CLEAR sweep, timestep run, output drain and done pulse
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        spk_valid_d = spk_valid_q;
        spk_data_d  = spk_data_q;
        spk_count_d = spk_count_q;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        cur_ready_c = (state_q == ST_RUN) && (!spk_valid_q || bus.spk_ready);

        if (spk_valid_q && bus.spk_ready) begin
            spk_valid_d = 1'b0;
        end

        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                if (last_row) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + PW'(1);
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end else if (go) begin
                    state_d     = ST_RUN;
                    ptr_d       = '0;
                    spk_count_d = '0;
                end
            end
            ST_RUN: begin
                if (bus.cur_valid && cur_ready_c) begin
                    mem_we      = 1'b1;
                    mem_wdata   = lane_v;
                    spk_valid_d = 1'b1;
                    spk_data_d  = lane_fire;
                    spk_count_d = spk_count_q + popcount(lane_fire);
                    if (last_row) begin
                        state_d = ST_DRAIN;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + PW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!spk_valid_q) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            ptr_q       <= '0;
            spk_valid_q <= 1'b0;
            spk_data_q  <= '0;
            spk_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            spk_valid_q <= spk_valid_d;
            spk_data_q  <= spk_data_d;
            spk_count_q <= spk_count_d;
        end
    end

    // Membrane rows; contents are defined by the CLEAR sweep that follows reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ptr_q] <= mem_wdata;
        end
    end

    assign bus.cur_ready = cur_ready_c;
    assign bus.spk_valid = spk_valid_q;
    assign bus.spk_data  = spk_data_q;
    assign spk_count     = spk_count_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_FIN);
endmodule

// File: tb/tb_snn_lif_bank.sv
// tb/tb_snn_lif_bank.sv - scoreboard bench for the LIF neuron bank
module tb_snn_lif_bank;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               go;
    logic               clear;
    logic signed [15:0] cfg_threshold;
    logic               cfg_leak_en;
    logic               cfg_sub_reset;
    logic [3:0]         spk_count;
    logic               busy;
    logic               done;

    int                 tests = 0;
    int                 fails = 0;
    logic [1:0]         exp_q[$];
    bit                 sb_ignore = 1'b0;

    always #5 clk = ~clk;

    snn_lif_bank_if #(.LANES(2), .VW(16)) bus ();

    snn_lif_bank #(
        .NUM_NEURONS (8),
        .LANES       (2),
        .VW          (16),
        .LEAK_SHIFT  (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .go            (go),
        .clear         (clear),
        .cfg_threshold (cfg_threshold),
        .cfg_leak_en   (cfg_leak_en),
        .cfg_sub_reset (cfg_sub_reset),
        .bus           (bus.slave),
        .spk_count     (spk_count),
        .busy          (busy),
        .done          (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0][31:0] uni(input int c0, input int c1);
        logic [31:0] w;
        w = {c1[15:0], c0[15:0]};
        return {4{w}};
    endfunction

    task automatic monitor();
        logic       held = 1'b0;
        logic [1:0] held_data = '0;
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n || sb_ignore) begin
                held = 1'b0;
            end else begin
                if (held) check("stall_hold", {bus.spk_valid, bus.spk_data}, {1'b1, held_data});
                if (bus.spk_valid && !bus.spk_ready) check("stall_cur_ready", bus.cur_ready, 0);
                if (bus.spk_valid && bus.spk_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_beat: got spike beat %b, required none", bus.spk_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("spk_beat", bus.spk_data, e);
                    end
                end
                held      = bus.spk_valid && !bus.spk_ready;
                held_data = bus.spk_data;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        @(negedge clk);
        check({tag, "_cur_ready"}, bus.cur_ready, 0);
        check({tag, "_spk_valid"}, bus.spk_valid, 0);
        check({tag, "_spk_data"},  bus.spk_data, 0);
        check({tag, "_spk_count"}, spk_count, 0);
        check({tag, "_busy"},      busy, 1);
        check({tag, "_done"},      done, 0);
    endtask

    task automatic wait_idle(output int n, output bit saw_done);
        n = 0;
        saw_done = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
            if (!busy) break;
            n++;
        end
        tick();
    endtask

    task automatic run_step(input logic [3:0][31:0] data, input logic [7:0] exp_fire,
                            input int exp_cnt, input bit bp, input string tag);
        logic [3:0] pat = 4'b1001;
        int  beats = 0;
        int  cyc = 0;
        int  done_cyc = -1;
        bit  fin = 1'b0;
        logic rdy;
        for (int b = 0; b < 4; b++) exp_q.push_back(exp_fire[2*b +: 2]);
        go            = 1'b1;
        bus.cur_valid = 1'b1;
        bus.cur_data  = data[0];
        bus.spk_ready = bp ? pat[0] : 1'b1;
        while (!fin && cyc < 200) begin
            @(negedge clk);
            rdy = bus.cur_ready;
            if (done) begin
                fin = 1'b1;
                done_cyc = cyc;
            end
            tick();
            go = 1'b0;
            if (rdy && bus.cur_valid) begin
                beats++;
                if (beats == 4) bus.cur_valid = 1'b0;
                else bus.cur_data = data[beats];
            end
            cyc++;
            if (bp) bus.spk_ready = pat[cyc % 4];
        end
        bus.spk_ready = 1'b1;
        check({tag, "_done_seen"}, fin, 1);
        if (!bp) check({tag, "_done_latency"}, done_cyc, 7);
        check({tag, "_beats_taken"}, beats, 4);
        check({tag, "_count"}, spk_count, exp_cnt);
        check({tag, "_drained"}, exp_q.size(), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        tick();
    endtask

    initial begin
        int n;
        bit saw_done;
        logic [3:0][31:0] d;

        fork
            monitor();
        join_none

        rst_n = 1'b0;
        go = 1'b0;
        clear = 1'b0;
        cfg_threshold = 16'sd100;
        cfg_leak_en = 1'b0;
        cfg_sub_reset = 1'b0;
        bus.cur_valid = 1'b0;
        bus.cur_data = '0;
        bus.spk_ready = 1'b1;

        tick();
        check_reset_values("reset");
        tick();
        rst_n = 1'b1;
        wait_idle(n, saw_done);
        check("reset_clear_cycles", n, 4);

        run_step(uni(0, 0), 8'h00, 0, 1'b0, "zero");
        run_step(uni(60, 60), 8'h00, 0, 1'b0, "int60_a");
        run_step(uni(60, 60), 8'hff, 8, 1'b0, "int60_b");

        cfg_leak_en = 1'b1;
        cfg_sub_reset = 1'b1;
        run_step(uni(150, 150), 8'hff, 8, 1'b0, "leak_fire");
        run_step(uni(0, 0), 8'h00, 0, 1'b0, "leak_decay");

        cfg_leak_en = 1'b0;
        run_step(uni(61, 62), 8'haa, 4, 1'b0, "v38_probe");
        cfg_sub_reset = 1'b0;
        run_step(uni(1, 99), 8'h55, 4, 1'b0, "thr_equal_a");
        run_step(uni(0, 1), 8'haa, 4, 1'b0, "thr_equal_b");

        cfg_threshold = 16'sd32767;
        run_step(uni(32767, 32767), 8'hff, 8, 1'b0, "sat_max_a");
        run_step(uni(32767, 32767), 8'hff, 8, 1'b0, "sat_max_b");
        run_step(uni(20000, 20000), 8'h00, 0, 1'b0, "sat_acc_a");
        run_step(uni(20000, 20000), 8'hff, 8, 1'b0, "sat_acc_b");
        run_step(uni(-32768, -32768), 8'h00, 0, 1'b0, "sat_neg_a");
        run_step(uni(-32768, -32768), 8'h00, 0, 1'b0, "sat_neg_b");
        cfg_threshold = 16'sd0;
        run_step(uni(32767, 32767), 8'h00, 0, 1'b0, "sat_neg_probe");
        run_step(uni(1, 1), 8'hff, 8, 1'b0, "thr_zero");

        cfg_threshold = 16'sd100;
        d[0] = {16'd50, 16'd100};
        d[1] = {16'd100, 16'd50};
        d[2] = {16'd100, 16'd100};
        d[3] = {16'd0, 16'd0};
        run_step(d, 8'h39, 4, 1'b1, "backpressure");

        go = 1'b1;
        clear = 1'b1;
        tick();
        go = 1'b0;
        clear = 1'b0;
        wait_idle(n, saw_done);
        check("go_clear_cycles", n, 4);
        check("go_clear_no_done", saw_done, 0);
        run_step(uni(50, 50), 8'h00, 0, 1'b0, "after_clear");

        sb_ignore = 1'b1;
        d = uni(50, 50);
        bus.cur_data = d[0];
        go = 1'b1;
        bus.cur_valid = 1'b1;
        tick();
        go = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        bus.cur_valid = 1'b0;
        check_reset_values("midrun");
        tick();
        rst_n = 1'b1;
        wait_idle(n, saw_done);
        check("midrun_clear_cycles", n, 4);
        check("midrun_no_done", saw_done, 0);
        sb_ignore = 1'b0;
        run_step(uni(50, 50), 8'h00, 0, 1'b0, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
